// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the data stage.
// One transaction in flight; data wins ties except when fetch has been
// starved for STARVE_MAX consecutive data grants. Fetch flushes drop the
// in-flight instruction response without disturbing the bus handshake.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            if_req_i,
    input  logic [AW-1:0]   if_addr_i,
    input  logic            if_flush_i,
    output logic            if_valid_o,
    output logic [DW-1:0]   if_data_o,
    input  logic            dm_req_i,
    input  logic            dm_we_i,
    input  logic [AW-1:0]   dm_addr_i,
    input  logic [DW-1:0]   dm_wdata_i,
    input  logic [DW/8-1:0] dm_be_i,
    output logic            dm_valid_o,
    output logic [DW-1:0]   dm_rdata_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW-1:0]   mem_wdata_o,
    output logic [DW/8-1:0] mem_be_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [DW-1:0]   mem_rdata_i,
    output logic            busy_o
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t            state_q, state_d;
    logic              owner_dm_q;   // 1 = data stage owns the port, 0 = fetch
    logic              drop_q;       // fetch response must be swallowed
    logic [SW-1:0]     starve_q;
    logic              req_we_q;
    logic [AW-1:0]     req_addr_q;
    logic [DW-1:0]     req_wdata_q;
    logic [DW/8-1:0]   req_be_q;

    logic              if_elig, dm_elig, arb_open;
    logic              grant_if, grant_dm;
    logic              rsp_fire, if_deliver;

    // Arbitration: only in IDLE and never in a response cycle, so a requester
    // gets its valid cycle to present the next request before arbitration.
    always_comb begin
        if_elig  = if_req_i && !if_valid_o;
        dm_elig  = dm_req_i && !dm_valid_o;
        arb_open = (state_q == IDLE) && !if_valid_o && !dm_valid_o;
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (arb_open) begin
            if (dm_elig && !(if_elig && (starve_q == SW'(STARVE_MAX))))
                grant_dm = 1'b1;
            else if (if_elig)
                grant_if = 1'b1;
        end
    end

    // Response qualification: a fetch response is delivered unless dropped,
    // including a flush arriving in the same cycle as the response.
    always_comb begin
        rsp_fire   = (state_q == RESP) && mem_rvalid_i;
        if_deliver = rsp_fire && !owner_dm_q && !drop_q && !if_flush_i;
    end

    // Next-state logic for the bus handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_if || grant_dm) state_d = REQ;
            REQ:     if (mem_gnt_i)            state_d = RESP;
            RESP:    if (mem_rvalid_i)         state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Latch owner and request fields at grant; held stable through REQ.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner_dm_q  <= 1'b0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_be_q    <= '0;
        end else if (grant_dm) begin
            owner_dm_q  <= 1'b1;
            req_we_q    <= dm_we_i;
            req_addr_q  <= dm_addr_i;
            req_wdata_q <= dm_wdata_i;
            req_be_q    <= dm_be_i;
        end else if (grant_if) begin
            owner_dm_q  <= 1'b0;
            req_we_q    <= 1'b0;
            req_addr_q  <= if_addr_i;
            req_wdata_q <= '0;
            req_be_q    <= '1;
        end
    end

    // Starvation counter: counts data grants that bypassed a waiting fetch.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            starve_q <= '0;
        else if (!if_req_i || grant_if)
            starve_q <= '0;
        else if (grant_dm && (starve_q != SW'(STARVE_MAX)))
            starve_q <= starve_q + 1'b1;
    end

    // Drop flag: armed by a flush while fetch owns an active transaction.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            drop_q <= 1'b0;
        else if (state_q == IDLE)
            drop_q <= 1'b0;
        else if (if_flush_i && !owner_dm_q)
            drop_q <= 1'b1;
    end

    // Registered responses: one-cycle valid pulses, data held until the next one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if_valid_o <= 1'b0;
            if_data_o  <= '0;
            dm_valid_o <= 1'b0;
            dm_rdata_o <= '0;
        end else begin
            if_valid_o <= if_deliver;
            dm_valid_o <= rsp_fire && owner_dm_q;
            if (if_deliver)
                if_data_o <= mem_rdata_i;
            if (rsp_fire && owner_dm_q)
                dm_rdata_o <= req_we_q ? '0 : mem_rdata_i;
        end
    end

    assign mem_req_o   = (state_q == REQ);
    assign mem_we_o    = req_we_q;
    assign mem_addr_o  = req_addr_q;
    assign mem_wdata_o = req_wdata_q;
    assign mem_be_o    = req_be_q;
    assign busy_o      = (state_q != IDLE);

endmodule
